rocket_launch_manager: RTL and testbench

//  Launch side of the single-rocket interface. Owns a pool of NUM_ROCKETS rocket slots.

---
 rtl/rocket_launch_manager.sv | 152 +++++++++++++++
 tb/tb_rocket_launch_manager.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rocket_launch_manager.sv
// Launch side of the rocket pool: picks the lowest free slot on a fire request,
// drives the shared launch buses, and retires slots on border/hit after a short blanking window.
module rocket_launch_manager #(
    parameter int NUM_ROCKETS     = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ROCKET_SPEED    = -256,
    parameter int X_OFFSET        = 14,
    parameter int Y_OFFSET        = -10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   fireRequest,
    input  logic signed [10:0]     shooterX,
    input  logic signed [10:0]     shooterY,
    input  logic [NUM_ROCKETS-1:0] reachedBorder,
    input  logic [NUM_ROCKETS-1:0] rocketHit,
    output logic [NUM_ROCKETS-1:0] isActive,
    output logic signed [10:0]     initialX,
    output logic signed [10:0]     initialY,
    output logic signed [10:0]     initialSpeed,
    output logic                   fireAck,
    output logic                   fireDenied,
    output logic [3:0]             activeCount
);

    localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic signed [11:0] X_OFF = 12'(X_OFFSET);
    localparam logic signed [11:0] Y_OFF = 12'(Y_OFFSET);
    localparam logic signed [11:0] X_MAX = 12'sd639;
    localparam logic signed [11:0] Y_MAX = 12'sd479;
    localparam logic signed [10:0] SPEED = 11'(ROCKET_SPEED);

    typedef enum logic {READY, COOLDOWN} state_t;

    function automatic logic signed [10:0] sat_coord(input logic signed [11:0] v,
                                                     input logic signed [11:0] hi);
        if (v < 12'sd0) return 11'sd0;
        if (v > hi)     return hi[10:0];
        return v[10:0];
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_ROCKETS-1:0]  act_q, act_d;
    logic [1:0]              blank_q [NUM_ROCKETS];
    logic [1:0]              blank_d [NUM_ROCKETS];
    logic signed [10:0]      x_q, x_d, y_q, y_d, spd_q, spd_d;
    logic                    ack_q, ack_d, den_q, den_d;
    logic [NUM_ROCKETS-1:0]  free_mask, kill;
    logic                    found, launch;
    logic signed [11:0]      sum_x, sum_y;
    logic [3:0]              pop;

    assign sum_x = $signed({shooterX[10], shooterX}) + X_OFF;
    assign sum_y = $signed({shooterY[10], shooterY}) + Y_OFF;

    // Slot selection and retire qualification work on the registered active mask.
    always_comb begin
        free_mask = '0;
        found     = 1'b0;
        kill      = '0;
        for (int k = 0; k < NUM_ROCKETS; k++) begin
            if (!act_q[k] && !found) begin
                free_mask[k] = 1'b1;
                found        = 1'b1;
            end
            kill[k] = act_q[k] && (blank_q[k] == 2'd0) && (reachedBorder[k] || rocketHit[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        launch  = 1'b0;
        den_d   = 1'b0;
        case (state_q)
            READY: begin
                if (fireRequest) begin
                    if (found) begin
                        launch = 1'b1;
                        if (COOLDOWN_FRAMES > 0) begin
                            state_d = COOLDOWN;
                            cnt_d   = CW'(COOLDOWN_FRAMES);
                        end
                    end else begin
                        den_d = 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                den_d = fireRequest;
                if (startOfFrame) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    always_comb begin
        act_d = (act_q & ~kill) | (launch ? free_mask : '0);
        ack_d = launch;
        x_d   = launch ? sat_coord(sum_x, X_MAX) : x_q;
        y_d   = launch ? sat_coord(sum_y, Y_MAX) : y_q;
        spd_d = launch ? SPEED : spd_q;
        for (int k = 0; k < NUM_ROCKETS; k++) begin
            if (launch && free_mask[k])  blank_d[k] = 2'd2;
            else if (blank_q[k] != 2'd0) blank_d[k] = blank_q[k] - 2'd1;
            else                         blank_d[k] = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
            cnt_q   <= '0;
            act_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            spd_q   <= '0;
            ack_q   <= 1'b0;
            den_q   <= 1'b0;
            for (int k = 0; k < NUM_ROCKETS; k++) blank_q[k] <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            x_q     <= x_d;
            y_q     <= y_d;
            spd_q   <= spd_d;
            ack_q   <= ack_d;
            den_q   <= den_d;
            for (int k = 0; k < NUM_ROCKETS; k++) blank_q[k] <= blank_d[k];
        end
    end

    always_comb begin
        pop = 4'd0;
        for (int k = 0; k < NUM_ROCKETS; k++) pop = pop + 4'(act_q[k]);
    end

    assign isActive     = act_q;
    assign initialX     = x_q;
    assign initialY     = y_q;
    assign initialSpeed = spd_q;
    assign fireAck      = ack_q;
    assign fireDenied   = den_q;
    assign activeCount  = pop;

endmodule

// File: tb/tb_rocket_launch_manager.sv
// Directed-vector bench for rocket_launch_manager (COOLDOWN_FRAMES=2, other parameters default).
module tb_rocket_launch_manager;

    logic              clk = 1'b0;
    logic              reset, startOfFrame, fireRequest;
    logic signed [10:0] shooterX, shooterY;
    logic [3:0]        reachedBorder, rocketHit;
    logic [3:0]        isActive;
    logic signed [10:0] initialX, initialY, initialSpeed;
    logic              fireAck, fireDenied;
    logic [3:0]        activeCount;

    int n_tests = 0;
    int n_fail  = 0;

    rocket_launch_manager #(
        .NUM_ROCKETS(4), .COOLDOWN_FRAMES(2), .ROCKET_SPEED(-256),
        .X_OFFSET(14), .Y_OFFSET(-10)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fireRequest(fireRequest),
        .shooterX(shooterX), .shooterY(shooterY),
        .reachedBorder(reachedBorder), .rocketHit(rocketHit),
        .isActive(isActive), .initialX(initialX), .initialY(initialY),
        .initialSpeed(initialSpeed), .fireAck(fireAck), .fireDenied(fireDenied),
        .activeCount(activeCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, sof, fire;
        int         sx, sy;
        logic [3:0] rb, hit;
        logic [3:0] act;
        int         x, y, spd;
        logic       ack, den;
        int         cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, sof, fire, input int sx, sy, input logic [3:0] rb, hit,
                       input logic [3:0] act, input int x, y, spd, input logic ack, den,
                       input int cnt);
        vec_t v;
        v = '{rst, sof, fire, sx, sy, rb, hit, act, x, y, spd, ack, den, cnt};
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, sof, fire, input int sx, sy, input logic [3:0] rb, hit);
        reset = rst; startOfFrame = sof; fireRequest = fire;
        shooterX = 11'(sx); shooterY = 11'(sy);
        reachedBorder = rb; rocketHit = hit;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int ack_cycles[$];
    int waited;
    logic got_ack;

    initial begin
        drive(1, 0, 0, 100, 400, 4'h0, 4'h0);
        //  rst sof fire  sx   sy   rb    hit   | act   x    y    spd  ack den cnt
        add(1, 0, 0, 100, 400, 4'h0, 4'h0,  4'h0,   0,   0,    0, 0, 0, 0);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 1, 0, 1);
        add(0, 0, 0, 100, 400, 4'h1, 4'h0,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 0, 1, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 0, 100, 400, 4'h1, 4'h0,  4'h0, 114, 390, -256, 0, 0, 0);
        add(0, 1, 0, 100, 400, 4'h0, 4'h0,  4'h0, 114, 390, -256, 0, 0, 0);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'h0, 114, 390, -256, 0, 1, 0);
        add(0, 0, 1, 630,   5, 4'h0, 4'h0,  4'h1, 639,   0, -256, 1, 0, 1);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'h1, 639,   0, -256, 0, 1, 1);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'h1, 639,   0, -256, 0, 1, 1);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'h1, 639,   0, -256, 0, 1, 1);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'h3, 114, 390, -256, 1, 0, 2);
        add(0, 1, 1, -20, 500, 4'h0, 4'h0,  4'h3, 114, 390, -256, 0, 1, 2);
        add(0, 1, 1, -20, 500, 4'h0, 4'h0,  4'h3, 114, 390, -256, 0, 1, 2);
        add(0, 0, 1, -20, 500, 4'h0, 4'h0,  4'h7,   0, 479, -256, 1, 0, 3);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'h7,   0, 479, -256, 0, 1, 3);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'h7,   0, 479, -256, 0, 1, 3);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'hF, 114, 390, -256, 1, 0, 4);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'hF, 114, 390, -256, 0, 1, 4);
        add(0, 1, 1, 100, 400, 4'h0, 4'h0,  4'hF, 114, 390, -256, 0, 1, 4);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'hF, 114, 390, -256, 0, 1, 4);
        add(0, 0, 0, 100, 400, 4'h0, 4'h8,  4'h7, 114, 390, -256, 0, 0, 3);
        add(0, 0, 1, 100, 400, 4'h2, 4'h0,  4'hD, 114, 390, -256, 1, 0, 3);
        add(0, 0, 0, 100, 400, 4'h0, 4'hA,  4'hD, 114, 390, -256, 0, 0, 3);
        add(0, 0, 0, 100, 400, 4'h0, 4'h0,  4'hD, 114, 390, -256, 0, 0, 3);
        add(1, 0, 1, 100, 400, 4'h0, 4'h0,  4'h0,   0,   0,    0, 0, 0, 0);
        add(0, 0, 1, 100, 400, 4'h0, 4'h0,  4'h1, 114, 390, -256, 1, 0, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h1,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h1,  4'h1, 114, 390, -256, 0, 0, 1);
        add(0, 0, 0, 100, 400, 4'h0, 4'h1,  4'h0, 114, 390, -256, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].sof, vt[i].fire, vt[i].sx, vt[i].sy, vt[i].rb, vt[i].hit);
            step();
            chk($sformatf("v%0d.isActive", i),     isActive,     vt[i].act);
            chk($sformatf("v%0d.initialX", i),     initialX,     vt[i].x);
            chk($sformatf("v%0d.initialY", i),     initialY,     vt[i].y);
            chk($sformatf("v%0d.initialSpeed", i), initialSpeed, vt[i].spd);
            chk($sformatf("v%0d.fireAck", i),      fireAck,      vt[i].ack);
            chk($sformatf("v%0d.fireDenied", i),   fireDenied,   vt[i].den);
            chk($sformatf("v%0d.activeCount", i),  activeCount,  vt[i].cnt);
        end

        // Level-held fire with a frame pulse every 4th cycle: launches land 8 cycles apart.
        drive(1, 0, 0, 100, 400, 4'h0, 4'h0);
        step();
        chk("held.reset_act", isActive, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, (i % 4) == 3, 1, 100, 400, 4'h0, 4'h0);
            step();
            if (fireAck) ack_cycles.push_back(i);
            if (i == 1) chk("held.denied_in_cooldown", fireDenied, 1);
            if (i == 31) chk("held.denied_when_full", fireDenied, 1);
        end
        chk("held.ack_count", ack_cycles.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("held.ack_cycle%0d", j),
                (j < ack_cycles.size()) ? ack_cycles[j] : -1, j * 8);
        chk("held.all_active", isActive, 4'hF);
        chk("held.activeCount", activeCount, 4);

        // Kill everything while requesting: request is judged on the old mask, so it is denied.
        drive(0, 0, 1, 100, 400, 4'h0, 4'hF);
        step();
        chk("killall.act", isActive, 0);
        chk("killall.den", fireDenied, 1);
        chk("killall.ack", fireAck, 0);

        drive(0, 0, 1, 100, 400, 4'h0, 4'h0);
        waited  = 0;
        got_ack = 1'b0;
        while (!got_ack && waited < 8) begin
            step();
            waited++;
            got_ack = fireAck;
        end
        chk("relaunch.got_ack", got_ack, 1);
        chk("relaunch.latency", waited, 1);
        chk("relaunch.act", isActive, 4'h1);

        drive(0, 0, 0, 100, 400, 4'h0, 4'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
